// File: rtl/spe_pkg.sv
// Shared types for the sprite plot engine: FSM states, screen limits, request record.
package spe_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int ID_N     = 4;   // every encodable 2-bit id

  typedef enum logic [1:0] {S_IDLE, S_ERASE, S_DRAW} state_t;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] c;
  } req_t;

endpackage

// File: rtl/spe_if.sv
// Sprite update request handshake: transfer when req_valid && req_ready.
interface spe_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_id;
  logic [7:0] req_x;
  logic [7:0] req_y;
  logic [2:0] req_c;

  modport master (output req_valid, req_id, req_x, req_y, req_c, input req_ready);
  modport slave  (input req_valid, req_id, req_x, req_y, req_c, output req_ready);
endinterface

// File: rtl/spe_req_fifo.sv
// Request FIFO holding sprite updates.
// Latency: an entry pushed at edge N is visible at the head after edge N.
// Backpressure: full blocks push; a pop on empty is ignored.
module spe_req_fifo
  import spe_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic push,
  input  req_t push_dat,
  output logic full,
  input  logic pop,
  output req_t pop_dat,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  req_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/sprite_plot_engine.sv
// Erases each sprite's old box and draws its new one as single-pixel adapter writes.
// Latency: accept at edge N, pop at N+1, first vga_plot after N+2. Optional macro SPE_SKIP_DUP_EN.
// Backpressure: req_ready low while the request FIFO is full.
module sprite_plot_engine
  import spe_pkg::*;
#(
  parameter int         NUM_SPRITES  = 3,
  parameter int         BOX_W        = 2,
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [2:0] ERASE_COLOUR = 3'b000
) (
  input  logic       clock,
  input  logic       reset_n,
  spe_if.slave       req,
  output logic [7:0] vga_x,
  output logic [7:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy
);

  state_t     state, state_nxt;
  req_t       head;
  logic       full, empty, pop;
  logic [1:0] w_id;
  logic [7:0] w_x, w_y;
  logic [2:0] w_c;
  logic [1:0] ci, cj;
  logic       last_px, head_known, is_dup;
  logic [7:0] base_x, base_y;
  logic [8:0] sum_x, sum_y;
  logic       in_view;

  logic [ID_N-1:0] prev_valid;
  logic [7:0]      prev_x [ID_N];
  logic [7:0]      prev_y [ID_N];

  spe_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (req.req_valid),
    .push_dat ({req.req_id, req.req_x, req.req_y, req.req_c}),
    .full     (full),
    .pop      (pop),
    .pop_dat  (head),
    .empty    (empty)
  );

  assign req.req_ready = !full;
  assign busy          = (state != S_IDLE) || !empty;
  assign head_known    = ({1'b0, head.id} < 3'(NUM_SPRITES));
  assign last_px       = (ci == 2'(BOX_W - 1)) && (cj == 2'(BOX_W - 1));

`ifdef SPE_SKIP_DUP_EN
  logic [2:0] prev_c [ID_N];
  assign is_dup = prev_valid[head.id] && (head.x == prev_x[head.id]) &&
                  (head.y == prev_y[head.id]) && (head.c == prev_c[head.id]);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < ID_N; k++) prev_c[k] <= '0;
    end else if (state == S_DRAW && last_px) begin
      prev_c[w_id] <= w_c;
    end
  end
`else
  assign is_dup = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          // Unknown ids and exact repeats are consumed without plotting
          if (!head_known || is_dup) state_nxt = S_IDLE;
          else if (prev_valid[head.id]) state_nxt = S_ERASE;
          else state_nxt = S_DRAW;
        end
      end
      S_ERASE: if (last_px) state_nxt = S_DRAW;
      S_DRAW:  if (last_px) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      w_id <= '0;
      w_x  <= '0;
      w_y  <= '0;
      w_c  <= '0;
      ci   <= '0;
      cj   <= '0;
    end else begin
      if (pop) begin
        w_id <= head.id;
        w_x  <= head.x;
        w_y  <= head.y;
        w_c  <= head.c;
      end
      if (pop || last_px) begin
        ci <= '0;
        cj <= '0;
      end else if (state != S_IDLE) begin
        if (ci == 2'(BOX_W - 1)) begin
          ci <= '0;
          cj <= cj + 1'b1;
        end else begin
          ci <= ci + 1'b1;
        end
      end
    end
  end

  assign base_x  = (state == S_ERASE) ? prev_x[w_id] : w_x;
  assign base_y  = (state == S_ERASE) ? prev_y[w_id] : w_y;
  assign sum_x   = {1'b0, base_x} + {7'b0, ci};
  assign sum_y   = {1'b0, base_y} + {7'b0, cj};
  // Off-screen pixels still spend their cycle, they just do not strobe
  assign in_view = (sum_x < 9'(SCREEN_W)) && (sum_y < 9'(SCREEN_H));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      vga_plot <= (state != S_IDLE) && in_view;
      if (state != S_IDLE) begin
        vga_x      <= sum_x[7:0];
        vga_y      <= sum_y[7:0];
        vga_colour <= (state == S_ERASE) ? ERASE_COLOUR : w_c;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_valid <= '0;
      for (int k = 0; k < ID_N; k++) begin
        prev_x[k] <= '0;
        prev_y[k] <= '0;
      end
    end else if (state == S_DRAW && last_px) begin
      prev_valid[w_id] <= 1'b1;
      prev_x[w_id]     <= w_x;
      prev_y[w_id]     <= w_y;
    end
  end

endmodule

// File: tb/tb_sprite_plot_engine.sv
// Directed bench for sprite_plot_engine: table of updates with hand-derived boxes plus corner sequences.
module tb_sprite_plot_engine;
  import spe_pkg::*;

  localparam int BW = 2;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] vga_x, vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot, busy;

  always #5 clock = ~clock;

  spe_if rq ();

  sprite_plot_engine dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (rq),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy)
  );

  typedef struct {
    logic [1:0] id;
    int         x;
    int         y;
    logic [2:0] c;
    bit         has_erase;
    int         ex;
    int         ey;
    bit         skip;
  } vec_t;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] c;
  } pix_t;

  vec_t tbl [7];
  pix_t got_q [$];
  pix_t exp_q [$];
  int   n_checks = 0;
  int   n_fail = 0;

  always @(negedge clock) begin
    if (reset_n && vga_plot) got_q.push_back({vga_x, vga_y, vga_colour});
  end

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic void add_box(input int bx, input int by, input logic [2:0] c);
    for (int j = 0; j < BW; j++)
      for (int i = 0; i < BW; i++)
        if (bx + i < 160 && by + j < 120)
          exp_q.push_back({8'(bx + i), 8'(by + j), c});
  endfunction

  function automatic void add_vec(input vec_t v);
    if (!v.skip) begin
      if (v.has_erase) add_box(v.ex, v.ey, 3'b000);
      add_box(v.x, v.y, v.c);
    end
  endfunction

  // Call away from a rising edge; returns at posedge+1 of the accepting edge.
  task automatic push(input vec_t v);
    rq.req_valid = 1'b1;
    rq.req_id    = v.id;
    rq.req_x     = 8'(v.x);
    rq.req_y     = 8'(v.y);
    rq.req_c     = v.c;
    for (int t = 0; t < 200; t++) begin
      if (rq.req_ready) begin
        @(posedge clock);
        #1;
        rq.req_valid = 1'b0;
        return;
      end
      @(posedge clock);
      #1;
    end
    rq.req_valid = 1'b0;
    chk("push_timeout", 0, 1);
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clock);
      if (!busy) done = 1'b1;
    end
    if (!done) chk({name, "_idle_timeout"}, 0, 1);
    repeat (3) @(negedge clock);
  endtask

  task automatic cmp_stream(input string name);
    int n;
    chk({name, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int k = 0; k < n; k++)
      chk($sformatf("%s_pix%0d", name, k), int'(got_q[k]), int'(exp_q[k]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int  lx [4];
    int  ly [4];
    bit  seen;

    rq.req_valid = 1'b0;
    rq.req_id    = '0;
    rq.req_x     = '0;
    rq.req_y     = '0;
    rq.req_c     = '0;

    tbl[0] = '{2'd0,  40,  60, 3'd4, 1'b0,  0,   0, 1'b0};
    tbl[1] = '{2'd0,  41,  60, 3'd4, 1'b1, 40,  60, 1'b0};
    tbl[2] = '{2'd1, 159, 119, 3'd2, 1'b0,  0,   0, 1'b0};
    tbl[3] = '{2'd3,  10,  10, 3'd7, 1'b0,  0,   0, 1'b1};
    tbl[4] = '{2'd2,  70,  30, 3'd6, 1'b0,  0,   0, 1'b0};
`ifdef SPE_SKIP_DUP_EN
    tbl[5] = '{2'd2,  70,  30, 3'd6, 1'b1, 70,  30, 1'b1};
`else
    tbl[5] = '{2'd2,  70,  30, 3'd6, 1'b1, 70,  30, 1'b0};
`endif
    tbl[6] = '{2'd1,   0,   0, 3'd1, 1'b1, 159, 119, 1'b0};

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_plot",   int'(vga_plot),     0);
    chk("rst_x",      int'(vga_x),        0);
    chk("rst_y",      int'(vga_y),        0);
    chk("rst_colour", int'(vga_colour),   0);
    chk("rst_ready",  int'(rq.req_ready), 1);
    chk("rst_busy",   int'(busy),         0);
    reset_n = 1'b1;

    // First-transaction latency and raster order
    @(posedge clock);
    #1;
    rq.req_valid = 1'b1;
    rq.req_id = 2'd0; rq.req_x = 8'd40; rq.req_y = 8'd60; rq.req_c = 3'd4;
    @(posedge clock);
    #1;
    rq.req_valid = 1'b0;
    @(negedge clock);
    chk("lat_n0_plot", int'(vga_plot), 0);
    chk("lat_n0_busy", int'(busy), 1);
    @(negedge clock);
    chk("lat_n1_plot", int'(vga_plot), 0);
    lx[0] = 40; lx[1] = 41; lx[2] = 40; lx[3] = 41;
    ly[0] = 60; ly[1] = 60; ly[2] = 61; ly[3] = 61;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk($sformatf("lat_plot%0d", k),   int'(vga_plot),   1);
      chk($sformatf("lat_x%0d", k),      int'(vga_x),      lx[k]);
      chk($sformatf("lat_y%0d", k),      int'(vga_y),      ly[k]);
      chk($sformatf("lat_c%0d", k),      int'(vga_colour), 4);
    end
    @(negedge clock);
    chk("lat_after_plot", int'(vga_plot), 0);
    chk("lat_after_busy", int'(busy), 0);
    got_q.delete();

    // Reset in the middle of a box
    push(tbl[0]);
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clock);
      if (vga_plot) seen = 1'b1;
    end
    chk("mid_seen_plot", int'(seen), 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_plot",  int'(vga_plot),     0);
    chk("mid_rst_busy",  int'(busy),         0);
    chk("mid_rst_ready", int'(rq.req_ready), 1);
    @(negedge clock);
    reset_n = 1'b1;
    got_q.delete();

    // Table, one update at a time (history carries from row to row)
    for (int i = 0; i < 7; i++) begin
      push(tbl[i]);
      wait_idle($sformatf("vecA%0d", i));
      add_vec(tbl[i]);
      cmp_stream($sformatf("vecA%0d", i));
    end

    // Same rows pushed back to back from a clean reset; FIFO fills up
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 6; i++) begin
      push(tbl[i]);
      add_vec(tbl[i]);
      if (i == 3) chk("burst_ready_before_full", int'(rq.req_ready), 1);
      if (i == 4) chk("burst_ready_full", int'(rq.req_ready), 0);
    end
    wait_idle("burst");
    cmp_stream("burst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
